reg_arbiter: RTL and testbench
==============================

REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width of every requester slot and of the register write port.
REQ-002 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-003 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset: synchronous, active-low (0 = reset).
REQ-005 Port req  input  NREQ  SHALL carry level requests, one bit per requester.
REQ-006 Port data_in  input  NREQ*WIDTH  SHALL carry write data; slot i is bits [i*WIDTH +: WIDTH].
REQ-007 Port en  input  1  SHALL enable arbitration; 0 = no new grant issued.
REQ-008 Port gnt  output  NREQ  SHALL be the registered one-hot grant, high for exactly one cycle per write.
REQ-009 Port load  output  1  SHALL drive the register's load input; high only in GRANT.
REQ-010 Port data_out  output  WIDTH  SHALL drive the register's data input with the granted slot's data.
REQ-011 Port wr_cnt  output  16  SHALL count completed grants.
REQ-012 Port busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-013 FSM SHALL have states IDLE, GRANT and COOLDOWN, held in registers.
REQ-014 IDLE: if en=1 and req!=0, the FSM SHALL go to GRANT; otherwise it SHALL stay in IDLE.
REQ-015 GRANT SHALL last exactly one cycle, then the FSM SHALL go to COOLDOWN.
REQ-016 COOLDOWN SHALL last exactly one cycle, then the FSM SHALL go to IDLE; req is ignored here.
REQ-017 Winner SHALL be the first asserted req bit found by searching upward from pointer ptr, wrapping NREQ-1 to 0.
REQ-018 On the IDLE->GRANT edge, data_out SHALL capture the winner's data_in slot, and gnt SHALL be set to the winner's one-hot code.
REQ-019 In GRANT, gnt and load SHALL both be high; in every other state they SHALL be 0.
REQ-020 data_out SHALL hold its last value outside GRANT.
REQ-021 Latency SHALL be one cycle from the req sample in IDLE to gnt/load high.
REQ-022 Peak throughput SHALL be one write per 3 cycles.
REQ-023 After a grant to i, ptr SHALL become (i+1) mod NREQ; ptr SHALL NOT change otherwise.
REQ-024 A req still high in the cycle after COOLDOWN SHALL be treated as a new request.
REQ-025 wr_cnt SHALL increment by 1 on each entry to GRANT and SHALL wrap from 0xFFFF to 0.
REQ-026 If en falls while in GRANT or COOLDOWN, the sequence SHALL complete; en is sampled only in IDLE.

Reset
REQ-027 While rst=0 at a clock edge, the next state SHALL be: IDLE; ptr=0; gnt=0; load=0; data_out=0; wr_cnt=0; busy=0.
REQ-028 Reset in GRANT or COOLDOWN SHALL abort the write; load SHALL be 0 in the cycle after the reset edge.

Structure
REQ-029 The state encoding typedef and the WIDTH/NREQ defaults SHALL live in the shared package reg_pkg.
REQ-030 The rotating-priority search SHALL be one combinational sub-module, rr_pick (inputs req, ptr; outputs one-hot and index).
REQ-031 The existing register block SHALL NOT be instantiated inside reg_arbiter; it SHALL be connected alongside it at the top level.

Verification
REQ-032 Reset: hold rst=0 for 2 cycles with req=4'b1111 -> gnt=0, load=0, data_out=0, wr_cnt=0, busy=0.
REQ-033 Single requester: req=4'b0100, slot2=8'h55 -> next cycle gnt=4'b0100, load=1, data_out=8'h55; then 2 idle cycles; wr_cnt=1.
REQ-034 Round robin: req=4'b1111 held, slots 8'h11/22/33/44 -> grant order 0,1,2,3,0; data_out 11,22,33,44,11; one grant every 3 cycles.
REQ-035 Wrap search: ptr=3 and req=4'b0011 -> gnt=4'b0001; next grant gnt=4'b0010.
REQ-036 Enable: en=0 with req=4'b1000 -> no grant for 5 cycles; raise en -> gnt=4'b1000 one cycle later.
REQ-037 Reset mid-op: rst=0 during GRANT (data 8'hAA) -> next cycle load=0, data_out=0, ptr=0, FSM in IDLE.

Source files
------------

// File: rtl/reg_pkg.sv
// Shared types and defaults for the register-write arbiter.
package reg_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;
  localparam int CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first asserted request at or above ptr, wrapping to 0.
module rr_pick
  import reg_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx
);

  // NOTE: every output gets a default before the loop, so no path leaves one unassigned (no latch).
  always_comb begin
    logic found;
    int   j;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found     = 1'b1;
        onehot[j] = 1'b1;
        idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/reg_arbiter.sv
// Round-robin arbiter feeding one shared register: IDLE -> GRANT -> COOLDOWN, one write per 3 cycles.
module reg_arbiter
  import reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data_in,
  input  logic                  en,
  output logic [NREQ-1:0]       gnt,
  output logic                  load,
  output logic [WIDTH-1:0]      data_out,
  output logic [CNT_W-1:0]      wr_cnt,
  output logic                  busy
);

  localparam int IW = $clog2(NREQ);

  state_t            state_q, state_d;
  logic              start;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     pick_idx;
  logic [NREQ-1:0]   pick_onehot;
  logic [NREQ-1:0]   gnt_q;
  logic [WIDTH-1:0]  data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WIDTH-1:0]  pick_data;
  logic [IW-1:0]     next_ptr;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign pick_data = data_in[int'(pick_idx)*WIDTH +: WIDTH];
  assign next_ptr  = (pick_idx == IW'(NREQ-1)) ? '0 : pick_idx + 1'b1;

  // en and req only matter in IDLE; GRANT and COOLDOWN run to completion.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && (|req)) begin
          state_d = ST_GRANT;
          start   = 1'b1;
        end
      end
      ST_GRANT:    state_d = ST_COOLDOWN;
      ST_COOLDOWN: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q  <= '0;
      gnt_q  <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      gnt_q  <= pick_onehot;
      data_q <= pick_data;
      ptr_q  <= next_ptr;
      cnt_q  <= cnt_q + 1'b1;
    end else begin
      gnt_q  <= '0;
    end
  end

  assign gnt      = gnt_q;
  assign load     = (state_q == ST_GRANT);
  assign busy     = (state_q != ST_IDLE);
  assign data_out = data_q;
  assign wr_cnt   = cnt_q;

endmodule

// File: tb/tb_reg_arbiter.sv
// Directed bench for reg_arbiter with a cycle-level reference model checked every cycle.
module tb_reg_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data_in;
  logic                  en;
  logic [NREQ-1:0]       gnt;
  logic                  load;
  logic [WIDTH-1:0]      data_out;
  logic [15:0]           wr_cnt;
  logic                  busy;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  reg_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_in  (data_in),
    .en       (en),
    .gnt      (gnt),
    .load     (load),
    .data_out (data_out),
    .wr_cnt   (wr_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference model: remaining busy cycles after a grant, plus the rotating pointer.
  int              m_left = 0;
  int              m_ptr  = 0;
  logic [NREQ-1:0] m_gnt  = '0;
  logic            m_load = 1'b0;
  logic [WIDTH-1:0] m_data = '0;
  logic [15:0]     m_cnt  = '0;

  function automatic int winner(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    if (!rst) begin
      m_left <= 0; m_ptr <= 0; m_gnt <= '0; m_load <= 1'b0; m_data <= '0; m_cnt <= '0;
    end else if (m_left == 0) begin
      w = winner(req, m_ptr);
      if (en && w >= 0) begin
        m_gnt  <= NREQ'(1) << w;
        m_load <= 1'b1;
        m_data <= data_in[w*WIDTH +: WIDTH];
        m_cnt  <= m_cnt + 16'd1;
        m_ptr  <= (w + 1) % NREQ;
        m_left <= 2;
      end else begin
        m_gnt <= '0; m_load <= 1'b0;
      end
    end else begin
      m_left <= m_left - 1;
      m_gnt  <= '0;
      m_load <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_gnt",  32'(gnt),      32'(m_gnt));
      check("model_load", 32'(load),     32'(m_load));
      check("model_data", 32'(data_out), 32'(m_data));
      check("model_cnt",  32'(wr_cnt),   32'(m_cnt));
      check("model_busy", 32'(busy),     32'(m_left != 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [WIDTH-1:0] v);
    data_in[i*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, required completion before %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; req = 4'b1111; en = 1'b1; data_in = '0;
    set_slot(0, 8'h11); set_slot(1, 8'h22); set_slot(2, 8'h33); set_slot(3, 8'h44);

    // Reset held 2 cycles with all requests high.
    tick(); chk_on = 1'b1; tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_load", 32'(load), 32'h0);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_cnt", 32'(wr_cnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // Single requester.
    rst = 1'b1; req = 4'b0100; set_slot(2, 8'h55);
    tick();
    check("single_gnt", 32'(gnt), 32'h4);
    check("single_load", 32'(load), 32'h1);
    check("single_data", 32'(data_out), 32'h55);
    req = 4'b0000;
    tick(); check("single_cd_load", 32'(load), 32'h0); check("single_cd_busy", 32'(busy), 32'h1);
    tick(); check("single_idle_busy", 32'(busy), 32'h0);
    check("single_cnt", 32'(wr_cnt), 32'h1);
    check("single_hold", 32'(data_out), 32'h55);

    // Round robin from ptr=0 with every request held.
    rst = 1'b0; tick(); rst = 1'b1;
    set_slot(2, 8'h33); req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr_gnt", 32'(gnt), 32'(1 << (i % 4)));
      check("rr_data", 32'(data_out), 32'(8'h11 * ((i % 4) + 1)));
      tick(); check("rr_cd_gnt", 32'(gnt), 32'h0);
      tick(); check("rr_idle_load", 32'(load), 32'h0);
    end
    check("rr_cnt", 32'(wr_cnt), 32'd5);
    req = 4'b0000;

    // Move ptr to 3, then wrap search.
    req = 4'b0100; tick(); check("wrap_pre", 32'(gnt), 32'h4);
    req = 4'b0000; tick(); tick();
    req = 4'b0011; tick(); check("wrap_first", 32'(gnt), 32'h1);
    tick(); tick();
    tick(); check("wrap_second", 32'(gnt), 32'h2);
    req = 4'b0000; tick(); tick();

    // Enable gating; en dropped mid-sequence must not abort it.
    en = 1'b0; req = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      tick(); check("en_off_gnt", 32'(gnt), 32'h0);
    end
    en = 1'b1; tick(); check("en_on_gnt", 32'(gnt), 32'h8);
    en = 1'b0; req = 4'b0000;
    tick(); check("en_drop_busy", 32'(busy), 32'h1);
    tick(); check("en_drop_idle", 32'(busy), 32'h0);
    en = 1'b1;

    // Reset during GRANT aborts the write and clears ptr.
    req = 4'b0001; set_slot(0, 8'hAA);
    tick(); check("mid_load", 32'(load), 32'h1); check("mid_data", 32'(data_out), 32'hAA);
    rst = 1'b0; req = 4'b0000;
    tick();
    check("mid_rst_load", 32'(load), 32'h0);
    check("mid_rst_data", 32'(data_out), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    rst = 1'b1; req = 4'b1111;
    tick(); check("mid_rst_ptr", 32'(gnt), 32'h1);
    req = 4'b0000; tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
